// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Fixed-latency data-memory responder for a memory-stage initiator. A request
// is accepted from IDLE or RESP. The responder then stalls for LATENCY cycles
// in WAIT and spends one cycle in RESP, where it pulses done. The array access
// (write, or read into data_out) happens on the edge that enters RESP.
//
// Parameters
//   LATENCY     wait cycles between acceptance and response (1..15)
//   DEPTH_LOG2  log2 of the number of 16-bit words in the storage array
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous, active-high reset
//   enable    in   request strobe
//   wr        in   1 = write, 0 = read (qualified by enable)
//   addr      in   byte address; word index = addr[DEPTH_LOG2:1]
//   data_in   in   write data
//   data_out  out  read data, valid while done=1, held otherwise
//   stall     out  high while in WAIT
//   done      out  one-cycle response pulse (RESP)
//   err       out  misaligned-access flag, valid while done=1
//
// Optional feature
//   DATA_MEM_ALIGN_CHECK_EN  when defined, a request with addr[0]=1 keeps the
//                            normal timing but does not touch the array. It
//                            responds with err=1 and data_out=0. When the
//                            macro is undefined, addr[0] is ignored and err
//                            stays 0.
//
// State | meaning
// IDLE  | no request outstanding
// WAIT  | request latched, counting down latency, stall=1
// RESP  | array accessed on entry, done=1 for this one cycle
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] LOADVALUE = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateType;

    stateType              state;
    logic [3:0]            cnt;
    logic                  latWr;
    logic [DEPTH_LOG2-1:0] latIdx;
    logic [15:0]           latData;
    logic                  errReg;
    logic                  accept;
    logic                  finishing;
    logic                  badAlign;
    logic                  memWe;
    logic                  unusedAddrBits;

    logic [15:0] mem [0:DEPTH-1];

    // The upper address bits only alias, and addr[0] matters only when the
    // alignment check is enabled.
    assign unusedAddrBits = ^addr;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic latOdd;
    assign badAlign = latOdd;
`else
    assign badAlign = 1'b0;
`endif

    assign accept    = enable && ((state == IDLE) || (state == RESP));
    assign finishing = (state == WAIT) && (cnt == 4'd0);

    // Reset gating keeps a pending write from landing if reset is asserted
    // in the same cycle that WAIT expires.
    assign memWe = finishing && latWr && !badAlign && !rst;

    // The storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[latIdx] <= latData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            latWr    <= 1'b0;
            latIdx   <= '0;
            latData  <= 16'h0000;
            data_out <= 16'h0000;
            stall    <= 1'b0;
            done     <= 1'b0;
            errReg   <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            latOdd   <= 1'b0;
`endif
        end else if (accept) begin
            state   <= WAIT;
            cnt     <= LOADVALUE;
            latWr   <= wr;
            latIdx  <= addr[DEPTH_LOG2:1];
            latData <= data_in;
            stall   <= 1'b1;
            done    <= 1'b0;
            errReg  <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            latOdd  <= addr[0];
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        stall <= 1'b0;
                        done  <= 1'b1;
                        if (badAlign) begin
                            errReg   <= 1'b1;
                            data_out <= 16'h0000;
                        end else if (latWr) begin
                            data_out <= 16'h0000;
                        end else begin
                            data_out <= mem[latIdx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    errReg <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign err = errReg;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of word count of the internal 16-bit storage array.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port enable  input  1  request strobe from the memory-stage initiator.
REQ-006 SHALL have port wr  input  1  1 = write request, 0 = read request; qualified by enable.
REQ-007 SHALL have port addr  input  16  byte address; word index = addr[DEPTH_LOG2:1].
REQ-008 SHALL have port data_in  input  16  write data.
REQ-009 SHALL have port data_out  output  16  read data; valid only while done=1.
REQ-010 SHALL have port stall  output  1  responder busy; initiator holds its request while high.
REQ-011 SHALL have port done  output  1  one-cycle response pulse.
REQ-012 SHALL have port err  output  1  misaligned-access flag; valid only while done=1.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-014 SHALL accept a request on a rising edge when enable=1 and state is IDLE or RESP.
REQ-015 On acceptance, SHALL latch addr, wr and data_in, enter WAIT and load a 4-bit counter with LATENCY-1.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0; RESP is entered exactly LATENCY edges after acceptance.
REQ-017 On the edge entering RESP, SHALL perform the array access: write latched data for a write, or register array[index] into data_out for a read.
REQ-018 SHALL hold data_out at 0 in a write response.
REQ-019 SHALL drive done=1 for exactly the one cycle spent in RESP.
REQ-020 SHALL drive stall=1 exactly while in WAIT; stall and done SHALL never be high together.
REQ-021 SHALL ignore enable while in WAIT, with no effect on latched request or array.
REQ-022 In RESP with enable=0, SHALL return to IDLE; with enable=1, SHALL accept the new request (REQ-015), giving back-to-back throughput of one request per LATENCY+1 cycles.
REQ-023 SHALL return write data on a read to the same index issued back-to-back after the write.
REQ-024 SHALL ignore addr bits above DEPTH_LOG2, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
REQ-025 SHALL hold data_out at its last value outside RESP.

Reset
REQ-026 While rst=1, SHALL force state IDLE, counter 0, data_out 0, stall 0, done 0, err 0 and latched-request registers 0.
REQ-027 SHALL discard any in-flight request on reset assertion; a pending write SHALL NOT modify the array.
REQ-028 SHALL NOT reset storage array contents.

Configuration
REQ-029 With macro DATA_MEM_ALIGN_CHECK_EN defined, an accepted request with addr[0]=1 SHALL follow normal timing, perform no array access, and respond with done=1, err=1, data_out=0.
REQ-030 Without DATA_MEM_ALIGN_CHECK_EN, SHALL ignore addr[0] and tie err to 0.

Verification
REQ-031 Reset mid-WAIT: write 0xBEEF to 0x0010 (LATENCY=2), assert rst one cycle after acceptance, then read 0x0010 -> returns the prior contents, not 0xBEEF; all outputs 0 during reset.
REQ-032 Basic write/read, LATENCY=2: write 0x1234 to 0x0004, then read 0x0004 -> stall high 2 cycles, done high 1 cycle per request, read data_out=0x1234.
REQ-033 Back-to-back: enable held high in RESP with write 0xA5A5 @0x0020, then read @0x0020 -> second request accepted in the write's RESP cycle; read done 3 cycles later with 0xA5A5.
REQ-034 Enable during WAIT: write 0x1111 @0x0002, toggle enable/addr=0x0008/wr=1 during stall -> only 0x0002 written; location 0x0008 unchanged.
REQ-035 Aliasing, DEPTH_LOG2=8: write 0x5555 @0x0200, read @0x0000 -> 0x5555.
REQ-036 Alignment, macro defined: read @0x0003 -> done=1, err=1, data_out=0; macro undefined: same read returns contents of 0x0002 with err=0.
